// File: rtl/bram_pkg.sv
// Shared constants, word type and power-up contents for the 8x18 operand banks.
// Latency/backpressure: none; constants only.
package bram_pkg;

    localparam int BRAM_DATA_W = 18;
    localparam int BRAM_DEPTH  = 8;
    localparam int BRAM_ADDR_W = 3;

    typedef logic [BRAM_DATA_W-1:0] bram_word_t;

    // Word i sits at bits [i*18 +: 18], so the lowest address is the rightmost word.
    localparam logic [BRAM_DEPTH*BRAM_DATA_W-1:0] INIT_BANK_A = {
        18'd7005, 18'd6005, 18'd5005, 18'd4005,
        18'd3005, 18'd2005, 18'd1005, 18'd5
    };

    localparam logic [BRAM_DEPTH*BRAM_DATA_W-1:0] INIT_BANK_B = {
        18'h00080, 18'h00040, 18'h00020, 18'h00010,
        18'h00008, 18'h00004, 18'h00002, 18'h00001
    };

    localparam logic [BRAM_DEPTH*BRAM_DATA_W-1:0] INIT_BANK_C = {
        18'h3FFF8, 18'h3FFF9, 18'h3FFFA, 18'h3FFFB,
        18'h3FFFC, 18'h3FFFD, 18'h3FFFE, 18'h3FFFF
    };

endpackage

// File: rtl/bram_sp_8x18_if.sv
// Single-port memory access bundle: address, enables and data in, read data out.
// No handshake; one access per enabled cycle.
interface bram_sp_8x18_if #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 3
);
    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;

    modport master (
        output ena,
        output wea,
        output addra,
        output dina,
        input  douta
    );

    modport slave (
        input  ena,
        input  wea,
        input  addra,
        input  dina,
        output douta
    );
endinterface

// File: rtl/bram_out_pipe.sv
// Optional extra read-data register; adds one cycle of latency, advances only when enabled.
// Asynchronously cleared by reset; no backpressure.
module bram_out_pipe #(
    parameter int DATA_W = 18
) (
    input  logic              clock_100Mhz,
    input  logic              reset,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_dat,
    output logic [DATA_W-1:0] o_dat
);

    logic [DATA_W-1:0] r_dat;

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            r_dat <= '0;
        end else if (i_en) begin
            r_dat <= i_dat;
        end
    end

    assign o_dat = r_dat;

endmodule

// File: rtl/bram_sp_8x18.sv
// Single-port WRITE_FIRST block RAM; read latency 1 (2 with OUT_REG), no stall or backpressure.
// Reset clears only the output registers; the array keeps its contents.
module bram_sp_8x18
    import bram_pkg::*;
#(
    parameter int                            DATA_W    = BRAM_DATA_W,
    parameter int                            DEPTH     = BRAM_DEPTH,
    parameter int                            ADDR_W    = BRAM_ADDR_W,
    parameter logic [DEPTH*DATA_W-1:0]       INIT_DATA = '0,
    parameter bit                            OUT_REG   = 1'b0
) (
    input  logic          clock_100Mhz,
    input  logic          reset,
    bram_sp_8x18_if.slave mem_if
);

    // Flat packed array with a declaration initialiser so the tools load power-up contents.
    logic [DEPTH*DATA_W-1:0] r_mem = INIT_DATA;
    logic [DATA_W-1:0]       r_dout;
    logic [DATA_W-1:0]       w_rd_word;
    logic [DATA_W-1:0]       w_next_dout;
    logic                    w_addr_ok;
    logic                    w_wr_en;

    assign w_wr_en = mem_if.ena & mem_if.wea & ~reset;

    always_comb begin
        w_rd_word = '0;
        w_addr_ok = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_if.addra == i[ADDR_W-1:0]) begin
                w_rd_word = r_mem[i*DATA_W +: DATA_W];
                w_addr_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_en && mem_if.addra == i[ADDR_W-1:0]) begin
                r_mem[i*DATA_W +: DATA_W] <= mem_if.dina;
            end
        end
    end

    // WRITE_FIRST: a write presents its own data; out-of-range addresses read as zero.
    always_comb begin
        w_next_dout = '0;
        if (w_addr_ok) begin
            w_next_dout = mem_if.wea ? mem_if.dina : w_rd_word;
        end
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            r_dout <= '0;
        end else if (mem_if.ena) begin
            r_dout <= w_next_dout;
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            bram_out_pipe #(
                .DATA_W (DATA_W)
            ) u_out_pipe (
                .clock_100Mhz (clock_100Mhz),
                .reset        (reset),
                .i_en         (mem_if.ena),
                .i_dat        (r_dout),
                .o_dat        (mem_if.douta)
            );
        end else begin : g_no_out_reg
            assign mem_if.douta = r_dout;
        end
    endgenerate

endmodule

// File: tb/tb_bram_sp_8x18.sv
// Directed bench: bank-A contents, one instance at latency 1 and one at latency 2, shared stimulus.
module tb_bram_sp_8x18;
    import bram_pkg::*;

    logic clock_100Mhz = 1'b0;
    logic reset        = 1'b1;
    int   n_checks     = 0;
    int   n_pass       = 0;

    always #5 clock_100Mhz = ~clock_100Mhz;

    bram_sp_8x18_if #(.DATA_W(BRAM_DATA_W), .ADDR_W(BRAM_ADDR_W)) bus_l1 ();
    bram_sp_8x18_if #(.DATA_W(BRAM_DATA_W), .ADDR_W(BRAM_ADDR_W)) bus_l2 ();

    bram_sp_8x18 #(
        .INIT_DATA (INIT_BANK_A),
        .OUT_REG   (1'b0)
    ) u_dut_l1 (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .mem_if       (bus_l1)
    );

    bram_sp_8x18 #(
        .INIT_DATA (INIT_BANK_A),
        .OUT_REG   (1'b1)
    ) u_dut_l2 (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .mem_if       (bus_l2)
    );

    task automatic chk(input string tag, input bram_word_t act, input bram_word_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %05h expected %05h", tag, act, exp);
    endtask

    task automatic drive(input logic en, input logic we, input logic [2:0] a, input bram_word_t d);
        bus_l1.ena = en; bus_l1.wea = we; bus_l1.addra = a; bus_l1.dina = d;
        bus_l2.ena = en; bus_l2.wea = we; bus_l2.addra = a; bus_l2.dina = d;
    endtask

    task automatic step();
        @(posedge clock_100Mhz);
        #1;
    endtask

    bram_word_t exp_init [8];
    logic [2:0] wrap_addr [4];
    bram_word_t wrap_exp  [4];

    initial begin
        for (int i = 0; i < 8; i++) exp_init[i] = bram_word_t'(i * 1000 + 5);
        wrap_addr = '{3'd6, 3'd7, 3'd0, 3'd1};
        wrap_exp  = '{18'd6005, 18'd7005, 18'd5, 18'd1005};

        drive(1'b0, 1'b0, 3'd0, '0);
        #2;
        chk("reset_l1", bus_l1.douta, 18'd0);
        chk("reset_l2", bus_l2.douta, 18'd0);
        step();
        step();
        #2 reset = 1'b0;

        // Init readback; latency-2 copy trails by one access.
        for (int a = 0; a < 8; a++) begin
            drive(1'b1, 1'b0, 3'(a), '0);
            step();
            chk($sformatf("init_l1_%0d", a), bus_l1.douta, exp_init[a]);
            chk($sformatf("init_l2_%0d", a), bus_l2.douta, (a == 0) ? 18'd0 : exp_init[a-1]);
        end
        drive(1'b1, 1'b0, 3'd0, '0);
        step();
        chk("init_l2_7", bus_l2.douta, 18'd7005);

        // Write-first
        drive(1'b1, 1'b1, 3'd3, 18'h2ABCD);
        step();
        chk("wf_write", bus_l1.douta, 18'h2ABCD);
        drive(1'b1, 1'b0, 3'd3, '0);
        step();
        chk("wf_read3", bus_l1.douta, 18'h2ABCD);
        chk("wf_l2_write", bus_l2.douta, 18'h2ABCD);
        drive(1'b1, 1'b0, 3'd4, '0);
        step();
        chk("wf_read4", bus_l1.douta, 18'd4005);

        // Enable gating
        drive(1'b1, 1'b0, 3'd2, '0);
        step();
        chk("en_read2", bus_l1.douta, 18'd2005);
        drive(1'b0, 1'b1, 3'd2, 18'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("en_hold_%0d", c), bus_l1.douta, 18'd2005);
        end
        chk("en_hold_l2", bus_l2.douta, 18'd4005);
        drive(1'b1, 1'b0, 3'd2, '0);
        step();
        chk("en_reread2", bus_l1.douta, 18'd2005);

        // Async reset mid-stream
        drive(1'b1, 1'b0, 3'd5, '0);
        step();
        chk("rst_pre5", bus_l1.douta, 18'd5005);
        drive(1'b1, 1'b0, 3'd6, '0);
        step();
        #2 reset = 1'b1;
        #1;
        chk("rst_async_l1", bus_l1.douta, 18'd0);
        chk("rst_async_l2", bus_l2.douta, 18'd0);
        drive(1'b1, 1'b1, 3'd5, 18'h12345);
        step();
        chk("rst_wr_blocked_out", bus_l1.douta, 18'd0);
        #2 reset = 1'b0;
        drive(1'b1, 1'b0, 3'd5, '0);
        step();
        chk("rst_survive5", bus_l1.douta, 18'd5005);
        chk("rst_l2_still0", bus_l2.douta, 18'd0);

        // Address wrap
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, wrap_addr[k], '0);
            step();
            chk($sformatf("wrap_%0d", k), bus_l1.douta, wrap_exp[k]);
        end

        // Full-width data
        drive(1'b1, 1'b1, 3'd7, 18'h3FFFF);
        step();
        chk("fw_wr7", bus_l1.douta, 18'h3FFFF);
        drive(1'b1, 1'b1, 3'd0, 18'h00000);
        step();
        chk("fw_wr0", bus_l1.douta, 18'h00000);
        drive(1'b1, 1'b0, 3'd7, '0);
        step();
        chk("fw_rd7", bus_l1.douta, 18'h3FFFF);
        drive(1'b1, 1'b0, 3'd0, '0);
        step();
        chk("fw_rd0", bus_l1.douta, 18'h00000);
        chk("fw_l2_rd7", bus_l2.douta, 18'h3FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
